pll_lock_monitor: RTL and testbench

//  Consumer side of the rPLL LOCK/RESET pair: supervises pll_lock, drives the PLL RESET input,
//  and releases the PLL-domain reset only once lock is proven stable. Runs on the free-running
//  12 MHz board clock feeding the PLL's clkin, so it keeps working when clkout stops.

---
 rtl/pll_lock_monitor.sv | 225 ++++++++++++++++++++++
 tb/tb_pll_lock_monitor.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/pll_lock_monitor.sv
// Purpose : supervise rPLL LOCK, drive PLL RESET, release PLL-domain reset once lock is proven stable.
// Latency : pll_lock -> FSM via 2-flop synchroniser (2 cycles); all outputs registered.
// Backpr. : none; free-running on sys_clk (the PLL clkin), so it keeps running when clkout stops.
//
// Ports:
//   sys_clk    in            12 MHz reference clock, same net as PLL clkin
//   sys_rst_n  in            asynchronous active-low reset
//   pll_lock   in            PLL LOCK, asynchronous to sys_clk
//   pll_reset  out           PLL RESET, active high
//   rst_out_n  out           active-low reset for PLL-domain logic (consumer re-synchronises it)
//   locked     out           1 while in RUN
//   state      out [2:0]     FSM state code: RESET=0 WAIT_LOCK=1 STABILIZE=2 RUN=3 FAIL=4
//   retry_cnt  out [CNT_W]   consecutive lock timeouts, saturating, cleared on RUN entry
//   loss_cnt   out [CNT_W]   RUN lock-loss events, saturating, cleared only by sys_rst_n
//   lock_fail  out           sticky retry-limit failure flag
//
// Optional feature macro: PLL_LOCK_MON_RETRY_LIMIT_EN
//   defined   : the MAX_RETRY-th consecutive timeout parks the FSM in FAIL until sys_rst_n.
//   undefined : retries forever, FAIL unreachable, lock_fail tied low, MAX_RETRY not present.
module pll_lock_monitor #(
  parameter int RST_PULSE     = 12,
  parameter int LOCK_TIMEOUT  = 12000,
  parameter int STABLE_CYCLES = 1200,
  parameter int LOSS_FILT     = 3,
  parameter int CNT_W         = 8
`ifdef PLL_LOCK_MON_RETRY_LIMIT_EN
  ,
  parameter int MAX_RETRY     = 4
`endif
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             pll_lock,
  output logic             pll_reset,
  output logic             rst_out_n,
  output logic             locked,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] retry_cnt,
  output logic [CNT_W-1:0] loss_cnt,
  output logic             lock_fail
);

  // Every counter is compared against P-1, so $clog2(P) bits suffice (min 1 bit for P == 1).
  localparam int PULSE_W = (RST_PULSE     > 1) ? $clog2(RST_PULSE)     : 1;
  localparam int TO_W    = (LOCK_TIMEOUT  > 1) ? $clog2(LOCK_TIMEOUT)  : 1;
  localparam int STB_W   = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam int FLT_W   = (LOSS_FILT     > 1) ? $clog2(LOSS_FILT)     : 1;

  localparam logic [PULSE_W-1:0] L_PULSE_LAST = PULSE_W'(RST_PULSE - 1);
  localparam logic [TO_W-1:0]    L_TO_LAST    = TO_W'(LOCK_TIMEOUT - 1);
  localparam logic [STB_W-1:0]   L_STB_LAST   = STB_W'(STABLE_CYCLES - 1);
  localparam logic [FLT_W-1:0]   L_FLT_LAST   = FLT_W'(LOSS_FILT - 1);

  typedef enum logic [2:0] {
    ST_RESET     = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABILIZE = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAIL      = 3'd4
  } state_e;

  state_e             r_state;
  logic               r_pll_reset;
  logic               r_rst_out_n;
  logic               r_locked;
  logic [CNT_W-1:0]   r_retry_cnt;
  logic [CNT_W-1:0]   r_loss_cnt;
  logic [PULSE_W-1:0] r_pulse_cnt;
  logic [TO_W-1:0]    r_to_cnt;
  logic [STB_W-1:0]   r_stb_cnt;
  logic [FLT_W-1:0]   r_flt_cnt;
  logic               r_lock_meta;
  logic               r_lock_s;

  logic               w_timeout;
  logic               w_to_fail;
  logic [CNT_W-1:0]   w_retry_inc;
  logic [CNT_W-1:0]   w_loss_inc;

  assign w_timeout   = (r_to_cnt == L_TO_LAST);
  assign w_retry_inc = (r_retry_cnt == {CNT_W{1'b1}}) ? r_retry_cnt : r_retry_cnt + CNT_W'(1);
  assign w_loss_inc  = (r_loss_cnt  == {CNT_W{1'b1}}) ? r_loss_cnt  : r_loss_cnt  + CNT_W'(1);

`ifdef PLL_LOCK_MON_RETRY_LIMIT_EN
  localparam logic [CNT_W-1:0] L_FAIL_AT = CNT_W'(MAX_RETRY - 1);
  logic r_lock_fail;
  // Compared against the pre-increment count: the MAX_RETRY-th timeout is the fatal one.
  assign w_to_fail = (r_retry_cnt == L_FAIL_AT);
  assign lock_fail = r_lock_fail;
`else
  assign w_to_fail = 1'b0;
  assign lock_fail = 1'b0;
`endif

  // Only CDC in the block: pll_lock is fully asynchronous to sys_clk.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_lock_meta <= 1'b0;
      r_lock_s    <= 1'b0;
    end else begin
      r_lock_meta <= pll_lock;
      r_lock_s    <= r_lock_meta;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state     <= ST_RESET;
      r_pll_reset <= 1'b1;
      r_rst_out_n <= 1'b0;
      r_locked    <= 1'b0;
      r_retry_cnt <= '0;
      r_loss_cnt  <= '0;
      r_pulse_cnt <= '0;
      r_to_cnt    <= '0;
      r_stb_cnt   <= '0;
      r_flt_cnt   <= '0;
`ifdef PLL_LOCK_MON_RETRY_LIMIT_EN
      r_lock_fail <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_RESET: begin
          if (r_pulse_cnt == L_PULSE_LAST) begin
            r_state     <= ST_WAIT_LOCK;
            r_pll_reset <= 1'b0;
            r_pulse_cnt <= '0;
          end else begin
            r_pulse_cnt <= r_pulse_cnt + PULSE_W'(1);
          end
        end

        // The timeout timer spans both lock-acquisition states and is checked
        // first, so it wins over any lock_s edge in the same cycle.
        ST_WAIT_LOCK, ST_STABILIZE: begin
          if (w_timeout) begin
            r_retry_cnt <= w_retry_inc;
            if (w_to_fail) begin
              r_state     <= ST_FAIL;
              r_pll_reset <= 1'b0;
              r_rst_out_n <= 1'b0;
              r_locked    <= 1'b0;
`ifdef PLL_LOCK_MON_RETRY_LIMIT_EN
              r_lock_fail <= 1'b1;
`endif
            end else begin
              r_state     <= ST_RESET;
              r_pll_reset <= 1'b1;
              r_rst_out_n <= 1'b0;
              r_locked    <= 1'b0;
              r_pulse_cnt <= '0;
              r_to_cnt    <= '0;
              r_stb_cnt   <= '0;
              r_flt_cnt   <= '0;
            end
          end else begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
            if (r_state == ST_WAIT_LOCK) begin
              if (r_lock_s) begin
                r_state   <= ST_STABILIZE;
                r_stb_cnt <= '0;
              end
            end else if (!r_lock_s) begin
              // Any dropout forfeits the accumulated stable time.
              r_state   <= ST_WAIT_LOCK;
              r_stb_cnt <= '0;
            end else if (r_stb_cnt == L_STB_LAST) begin
              r_state     <= ST_RUN;
              r_rst_out_n <= 1'b1;
              r_locked    <= 1'b1;
              r_retry_cnt <= '0;
              r_flt_cnt   <= '0;
            end else begin
              r_stb_cnt <= r_stb_cnt + STB_W'(1);
            end
          end
        end

        // rst_out_n stays high while the loss filter counts; only a confirmed
        // loss (LOSS_FILT consecutive low samples) tears the PLL domain down.
        ST_RUN: begin
          if (r_lock_s) begin
            r_flt_cnt <= '0;
          end else if (r_flt_cnt == L_FLT_LAST) begin
            r_loss_cnt  <= w_loss_inc;
            r_state     <= ST_RESET;
            r_pll_reset <= 1'b1;
            r_rst_out_n <= 1'b0;
            r_locked    <= 1'b0;
            r_pulse_cnt <= '0;
            r_to_cnt    <= '0;
            r_stb_cnt   <= '0;
            r_flt_cnt   <= '0;
          end else begin
            r_flt_cnt <= r_flt_cnt + FLT_W'(1);
          end
        end

        // Terminal until sys_rst_n; outputs were set on entry.
        ST_FAIL: begin
          r_state <= ST_FAIL;
        end

        default: begin
          r_state     <= ST_RESET;
          r_pll_reset <= 1'b1;
          r_rst_out_n <= 1'b0;
          r_locked    <= 1'b0;
          r_pulse_cnt <= '0;
          r_to_cnt    <= '0;
          r_stb_cnt   <= '0;
          r_flt_cnt   <= '0;
        end
      endcase
    end
  end

  assign pll_reset = r_pll_reset;
  assign rst_out_n = r_rst_out_n;
  assign locked    = r_locked;
  assign state     = r_state;
  assign retry_cnt = r_retry_cnt;
  assign loss_cnt  = r_loss_cnt;

endmodule

// File: tb/tb_pll_lock_monitor.sv
// Purpose : directed self-checking bench for pll_lock_monitor (shortened timeout/stable windows).
// Latency : cycle numbers below count sys_clk edges after sys_rst_n release.
// Backpr. : n/a; inputs driven 1 time unit after posedge, outputs sampled there too.
module tb_pll_lock_monitor;

  localparam int RP = 12;   // RST_PULSE
  localparam int LT = 100;  // LOCK_TIMEOUT (shortened)
  localparam int SC = 40;   // STABLE_CYCLES (shortened)
  localparam int LF = 3;    // LOSS_FILT
  localparam int CW = 8;

  logic          sys_clk = 1'b0;
  logic          sys_rst_n = 1'b0;
  logic          pll_lock = 1'b0;
  logic          pll_reset;
  logic          rst_out_n;
  logic          locked;
  logic [2:0]    state;
  logic [CW-1:0] retry_cnt;
  logic [CW-1:0] loss_cnt;
  logic          lock_fail;

  int n_checks = 0;
  int n_fail   = 0;

  pll_lock_monitor #(
    .RST_PULSE     (RP),
    .LOCK_TIMEOUT  (LT),
    .STABLE_CYCLES (SC),
    .LOSS_FILT     (LF),
    .CNT_W         (CW)
  ) u_dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .pll_lock  (pll_lock),
    .pll_reset (pll_reset),
    .rst_out_n (rst_out_n),
    .locked    (locked),
    .state     (state),
    .retry_cnt (retry_cnt),
    .loss_cnt  (loss_cnt),
    .lock_fail (lock_fail)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_state(input logic [2:0] s, input int max_cyc);
    int cyc;
    cyc = 0;
    while (state !== s && cyc < max_cyc) begin
      tick();
      cyc++;
    end
  endtask

  // Number of edges for which pll_reset stays high, starting from the current cycle.
  task automatic measure_pulse(output int n);
    n = 0;
    while (pll_reset === 1'b1 && n < 100) begin
      tick();
      n++;
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_state"},     32'(state),     32'd0);
    check({tag, "_pll_reset"}, 32'(pll_reset), 32'd1);
    check({tag, "_rst_out_n"}, 32'(rst_out_n), 32'd0);
    check({tag, "_locked"},    32'(locked),    32'd0);
    check({tag, "_retry"},     32'(retry_cnt), 32'd0);
    check({tag, "_loss"},      32'(loss_cnt),  32'd0);
    check({tag, "_lock_fail"}, 32'(lock_fail), 32'd0);
  endtask

  // Confirmed loss (lock low longer than the filter), then relock back to RUN.
  task automatic lose_and_relock();
    pll_lock = 1'b0;
    ticks(LF + 3);
    pll_lock = 1'b1;
    wait_state(3'd3, 4 * (RP + SC));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n;
    bit  saw_run, saw_stab, saw_reset;

    // ---- reset state ----
    ticks(3);
    check_reset_values("rst");

    // ---- 1: power-up, lock at cycle 50 ----
    sys_rst_n = 1'b1;
    measure_pulse(n);
    check("t1_pulse_len", 32'(n), RP);
    check("t1_wait_state", 32'(state), 32'd1);
    ticks(50 - RP);
    pll_lock = 1'b1;                      // seen at edge 51, lock_s at 52
    ticks(40);                            // edge 90: still stabilising
    check("t1_stab_edge90", 32'(state), 32'd2);
    check("t1_rstn_edge90", 32'(rst_out_n), 32'd0);
    ticks(4);                             // edge 94: RUN expected at 50+2+SC (+/-1)
    check("t1_run_state", 32'(state), 32'd3);
    check("t1_rst_out_n", 32'(rst_out_n), 32'd1);
    check("t1_locked", 32'(locked), 32'd1);
    check("t1_pll_reset", 32'(pll_reset), 32'd0);
    check("t1_retry", 32'(retry_cnt), 32'd0);
    check("t1_loss", 32'(loss_cnt), 32'd0);

    // ---- 3a: 2-cycle glitch in RUN is filtered ----
    pll_lock = 1'b0;
    ticks(2);
    pll_lock = 1'b1;
    for (int i = 0; i < 6; i++) check("t3_glitch_rstn", 32'(rst_out_n), 32'd1);
    ticks(6);
    check("t3_glitch_state", 32'(state), 32'd3);
    check("t3_glitch_loss", 32'(loss_cnt), 32'd0);

    // ---- 3b: 3-cycle loss is confirmed on the third synced-low sample ----
    pll_lock = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t3_loss_filtering_rstn", 32'(rst_out_n), 32'd1);
    end
    pll_lock = 1'b1;
    tick();
    check("t3_loss_still_run", 32'(state), 32'd3);
    tick();
    check("t3_loss_state", 32'(state), 32'd0);
    check("t3_loss_rstn", 32'(rst_out_n), 32'd0);
    check("t3_loss_locked", 32'(locked), 32'd0);
    check("t3_loss_cnt", 32'(loss_cnt), 32'd1);
    measure_pulse(n);
    check("t3_pulse_len", 32'(n), RP);
    wait_state(3'd3, 4 * (RP + SC));
    check("t3_relock_state", 32'(state), 32'd3);
    check("t3_relock_loss", 32'(loss_cnt), 32'd1);

    // ---- 6: async reset while in RUN with loss_cnt=5 ----
    for (int i = 0; i < 4; i++) lose_and_relock();
    check("t6_pre_loss", 32'(loss_cnt), 32'd5);
    check("t6_pre_state", 32'(state), 32'd3);
    sys_rst_n = 1'b0;
    #1;
    check_reset_values("t6");

    // ---- 4: lock toggling every 15 cycles in STABILIZE never reaches RUN ----
    pll_lock = 1'b0;
    ticks(3);
    sys_rst_n = 1'b1;
    ticks(RP);                            // edge 12: WAIT_LOCK, timer starts
    check("t4_wait_state", 32'(state), 32'd1);
    pll_lock = 1'b1;
    saw_run = 0; saw_stab = 0; saw_reset = 0;
    for (int k = RP + 1; k < RP + LT; k++) begin
      tick();
      if (state == 3'd3) saw_run = 1;
      if (state == 3'd2) saw_stab = 1;
      if (state == 3'd0) saw_reset = 1;
      if ((k - RP) % 15 == 0) pll_lock = ~pll_lock;
    end
    check("t4_no_run", 32'(saw_run), 32'd0);
    check("t4_stab_seen", 32'(saw_stab), 32'd1);
    check("t4_no_early_reset", 32'(saw_reset), 32'd0);
    tick();                               // edge 112: timeout
    check("t4_timeout_state", 32'(state), 32'd0);
    check("t4_timeout_pll_reset", 32'(pll_reset), 32'd1);
    check("t4_retry", 32'(retry_cnt), 32'd1);

    // ---- 2: lock held low, re-pulse every RP+LT cycles ----
    pll_lock = 1'b0;
    ticks(RP + LT - 1);                   // edge 223
    check("t2_before_to_state", 32'(state), 32'd1);
    check("t2_before_to_retry", 32'(retry_cnt), 32'd1);
    tick();                               // edge 224
    check("t2_to2_state", 32'(state), 32'd0);
    check("t2_to2_retry", 32'(retry_cnt), 32'd2);
`ifdef PLL_LOCK_MON_RETRY_LIMIT_EN
    // ---- 5: retry limit -> FAIL on the 4th timeout ----
    ticks(RP + LT);
    check("t5_to3_state", 32'(state), 32'd0);
    check("t5_to3_retry", 32'(retry_cnt), 32'd3);
    ticks(RP + LT);
    check("t5_fail_state", 32'(state), 32'd4);
    check("t5_fail_flag", 32'(lock_fail), 32'd1);
    check("t5_fail_retry", 32'(retry_cnt), 32'd4);
    check("t5_fail_pll_reset", 32'(pll_reset), 32'd0);
    check("t5_fail_rstn", 32'(rst_out_n), 32'd0);
    ticks(3 * (RP + LT));
    check("t5_fail_held", 32'(state), 32'd4);
    check("t5_fail_pll_reset_held", 32'(pll_reset), 32'd0);
    sys_rst_n = 1'b0;
    #1;
    check_reset_values("t5_rst");
    ticks(2);
    sys_rst_n = 1'b1;
    tick();
    check("t5_after_rst_state", 32'(state), 32'd0);
`else
    for (int r = 3; r <= 257; r++) begin
      ticks(RP + LT);
      check("t2_retry_step", 32'(retry_cnt), (r > 255) ? 32'd255 : 32'(r));
    end
    check("t2_sat_state", 32'(state), 32'd0);
    check("t2_no_fail", 32'(lock_fail), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
